// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded control, operands and register specifiers into EX.
// Latency: one clock from ID to EX; stall_id is combinational with no added delay.
// Backpressure: stall_id holds IF/ID while MEM stalls, a MUL occupies EX, or a load-use bubble is inserted.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   id_valid/opcode/pc/...           decoded instruction presented by ID (held by ID while stall_id=1)
//   id_ctrl[11:0]                    {reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src,
//                                     reg_write, jump, word, tlb_write, iret, ignore_op2}
//   flush                            squash EX contents and any MUL in progress
//   mem_stall                        MEM cannot accept; EX freezes completely
//   stall_id                         freeze IF/ID and the PC
//   ex_*                             registered EX-stage view of the instruction
//   ex_is_mul, mul_busy              EX holds a MUL / MUL still occupying EX
module id_ex_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int MUL_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [5:0]        id_opcode,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [11:0]       id_ctrl,
  input  logic              flush,
  input  logic              mem_stall,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_dest,
  output logic [11:0]       ex_ctrl,
  output logic              ex_is_mul,
  output logic              mul_busy
);

  // Bit positions inside the control word
  localparam int C_REG_DST    = 11;
  localparam int C_BRANCH     = 10;
  localparam int C_MEM_READ   = 9;
  localparam int C_MEM_WRITE  = 7;
  localparam int C_ALU_SRC    = 6;
  localparam int C_REG_WRITE  = 5;
  localparam int C_IGNORE_OP2 = 0;

  localparam logic [5:0] OP_MUL = 6'h02;

  // Counter holds the remaining extra cycles of a MUL, at most MUL_LATENCY-1.
  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);

  logic              ex_valid_q,   ex_valid_d;
  logic [DATA_W-1:0] ex_pc_q,      ex_pc_d;
  logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
  logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
  logic [DATA_W-1:0] ex_imm_q,     ex_imm_d;
  logic [REG_AW-1:0] ex_rs_q,      ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q,      ex_rt_d;
  logic [REG_AW-1:0] ex_dest_q,    ex_dest_d;
  logic [11:0]       ex_ctrl_q,    ex_ctrl_d;
  logic              ex_is_mul_q,  ex_is_mul_d;
  logic [CNT_W-1:0]  mul_cnt_q,    mul_cnt_d;

  logic              uses_rt;
  logic              load_use;
  logic              busy;
  logic              id_is_mul;
  logic [REG_AW-1:0] id_dest;

  // rt is a real source for R-type ALU ops, stores and branch compares.
  assign uses_rt = !id_ctrl[C_IGNORE_OP2] &
                   (!id_ctrl[C_ALU_SRC] | id_ctrl[C_MEM_WRITE] | id_ctrl[C_BRANCH]);

  // ex_dest is already zero for non-writers and bubbles, so the !=0 test also covers r0.
  assign load_use = id_valid & ex_valid_q & ex_ctrl_q[C_MEM_READ] & (ex_dest_q != '0) &
                    ((ex_dest_q == id_rs) | (uses_rt & (ex_dest_q == id_rt)));

  assign busy      = (mul_cnt_q != '0);
  assign id_is_mul = (id_opcode == OP_MUL);
  assign id_dest   = !id_ctrl[C_REG_WRITE] ? '0 :
                     (id_ctrl[C_REG_DST] ? id_rd : id_rt);

  // Gated by rst_n so a pending mem_stall cannot freeze fetch while in reset.
  assign stall_id = rst_n & (mem_stall | busy | load_use);

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_rs_data_d = ex_rs_data_q;
    ex_rt_data_d = ex_rt_data_q;
    ex_imm_d     = ex_imm_q;
    ex_rs_d      = ex_rs_q;
    ex_rt_d      = ex_rt_q;
    ex_dest_d    = ex_dest_q;
    ex_ctrl_d    = ex_ctrl_q;
    ex_is_mul_d  = ex_is_mul_q;
    mul_cnt_d    = mul_cnt_q;

    if (flush) begin
      // Data fields keep their values; only the qualifying state is cleared.
      ex_valid_d  = 1'b0;
      ex_ctrl_d   = '0;
      ex_dest_d   = '0;
      ex_is_mul_d = 1'b0;
      mul_cnt_d   = '0;
    end else if (mem_stall) begin
      // Full hold, including the MUL counter.
    end else if (busy) begin
      mul_cnt_d = mul_cnt_q - 1'b1;
    end else if (load_use || !id_valid) begin
      ex_valid_d  = 1'b0;
      ex_ctrl_d   = '0;
      ex_dest_d   = '0;
      ex_is_mul_d = 1'b0;
    end else begin
      ex_valid_d   = 1'b1;
      ex_pc_d      = id_pc;
      ex_rs_data_d = id_rs_data;
      ex_rt_data_d = id_rt_data;
      ex_imm_d     = id_imm;
      ex_rs_d      = id_rs;
      ex_rt_d      = id_rt;
      ex_dest_d    = id_dest;
      ex_ctrl_d    = id_ctrl;
      ex_is_mul_d  = id_is_mul;
      mul_cnt_d    = id_is_mul ? MUL_LOAD : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_dest_q    <= '0;
      ex_ctrl_q    <= '0;
      ex_is_mul_q  <= 1'b0;
      mul_cnt_q    <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm_q     <= ex_imm_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_dest_q    <= ex_dest_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_is_mul_q  <= ex_is_mul_d;
      mul_cnt_q    <= mul_cnt_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_pc      = ex_pc_q;
  assign ex_rs_data = ex_rs_data_q;
  assign ex_rt_data = ex_rt_data_q;
  assign ex_imm     = ex_imm_q;
  assign ex_rs      = ex_rs_q;
  assign ex_rt      = ex_rt_q;
  assign ex_dest    = ex_dest_q;
  assign ex_ctrl    = ex_ctrl_q;
  assign ex_is_mul  = ex_is_mul_q;
  assign mul_busy   = busy;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed instruction stream with a scoreboard of expected EX contents.
// Latency: checks one-edge ID->EX latch, stall_id cycle counts, bubbles, MUL hold, flush and reset.
// Backpressure: drives mem_stall and flush directly; ID re-presents while stall_id is high.
module tb_id_ex_stage;
  localparam int DATA_W      = 32;
  localparam int REG_AW      = 5;
  localparam int MUL_LATENCY = 4;

  // Control word constants: {reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src,
  //                          reg_write, jump, word, tlb_write, iret, ignore_op2}
  localparam logic [11:0] C_RTYPE = 12'h820;  // reg_dst | reg_write
  localparam logic [11:0] C_LDW   = 12'h368;  // mem_read | mem_to_reg | alu_src | reg_write | word
  localparam logic [11:0] C_STW   = 12'h0C8;  // mem_write | alu_src | word
  localparam logic [11:0] C_IGN   = 12'h821;  // R-type with ignore_op2
  localparam logic [11:0] C_TLBI  = 12'h826;  // R-type with tlb_write and iret
  localparam logic [11:0] C_NOWR  = 12'h800;  // reg_dst without reg_write

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_MUL = 6'h02;
  localparam logic [5:0] OP_LDW = 6'h23;
  localparam logic [5:0] OP_STW = 6'h2B;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              id_valid = 1'b0;
  logic [5:0]        id_opcode = '0;
  logic [DATA_W-1:0] id_pc = '0, id_rs_data = '0, id_rt_data = '0, id_imm = '0;
  logic [REG_AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic [11:0]       id_ctrl = '0;
  logic              flush = 1'b0;
  logic              mem_stall = 1'b0;
  logic              stall_id, ex_valid, ex_is_mul, mul_busy;
  logic [DATA_W-1:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_dest;
  logic [11:0]       ex_ctrl;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MUL_LATENCY(MUL_LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_pc(id_pc),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_ctrl(id_ctrl),
    .flush(flush), .mem_stall(mem_stall), .stall_id(stall_id), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_ctrl(ex_ctrl),
    .ex_is_mul(ex_is_mul), .mul_busy(mul_busy)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [11:0] ctrl;
    logic        is_mul;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Operand data is derived from the PC so each instruction carries distinct values.
  task automatic drive(input logic [5:0] op, input logic [31:0] pc, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [11:0] ctrl);
    id_valid   = 1'b1;
    id_opcode  = op;
    id_pc      = pc;
    id_rs_data = {16'hA000, pc[15:0]};
    id_rt_data = {16'hB000, pc[15:0]};
    id_imm     = {16'hC000, pc[15:0]};
    id_rs      = rs;
    id_rt      = rt;
    id_rd      = rd;
    id_ctrl    = ctrl;
  endtask

  task automatic push(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [11:0] ctrl, input logic [4:0] dest, input logic is_mul);
    exp_t e;
    e.pc      = pc;
    e.rs_data = {16'hA000, pc[15:0]};
    e.rt_data = {16'hB000, pc[15:0]};
    e.imm     = {16'hC000, pc[15:0]};
    e.rs      = rs;
    e.rt      = rt;
    e.dest    = dest;
    e.ctrl    = ctrl;
    e.is_mul  = is_mul;
    sb.push_back(e);
  endtask

  // Present one instruction, count the cycles ID is held, then let it latch.
  task automatic send(input logic [5:0] op, input logic [31:0] pc, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [11:0] ctrl,
                      input logic [4:0] exp_dest, input logic exp_mul, input int exp_stall,
                      input logic exp_valid_after);
    int n;
    @(negedge clk);
    drive(op, pc, rs, rt, rd, ctrl);
    push(pc, rs, rt, ctrl, exp_dest, exp_mul);
    #1;
    n = 0;
    while (stall_id && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk($sformatf("stall_cycles@%0h", pc), n, exp_stall);
    if (exp_stall > 0) chk($sformatf("ex_valid_before@%0h", pc), ex_valid, exp_valid_after);
    @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ex_valid"}, ex_valid, 0);
    chk({tag, "_ex_pc"}, ex_pc, 0);
    chk({tag, "_ex_rs_data"}, ex_rs_data, 0);
    chk({tag, "_ex_rt_data"}, ex_rt_data, 0);
    chk({tag, "_ex_imm"}, ex_imm, 0);
    chk({tag, "_ex_rs"}, ex_rs, 0);
    chk({tag, "_ex_rt"}, ex_rt, 0);
    chk({tag, "_ex_dest"}, ex_dest, 0);
    chk({tag, "_ex_ctrl"}, ex_ctrl, 0);
    chk({tag, "_ex_is_mul"}, ex_is_mul, 0);
    chk({tag, "_mul_busy"}, mul_busy, 0);
    chk({tag, "_stall_id"}, stall_id, 0);
  endtask

  // Monitor: each newly latched instruction in EX is compared to the scoreboard head.
  logic [31:0] last_pc = 32'hFFFF_FFFF;
  logic        prev_valid = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ex_valid && (!prev_valid || ex_pc != last_pc)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got pc %0h expected no instruction", ex_pc);
        end else begin
          e = sb.pop_front();
          chk($sformatf("sb_pc@%0h", e.pc), ex_pc, e.pc);
          chk($sformatf("sb_dest@%0h", e.pc), ex_dest, e.dest);
          chk($sformatf("sb_ctrl@%0h", e.pc), ex_ctrl, e.ctrl);
          chk($sformatf("sb_rs@%0h", e.pc), ex_rs, e.rs);
          chk($sformatf("sb_rt@%0h", e.pc), ex_rt, e.rt);
          chk($sformatf("sb_is_mul@%0h", e.pc), ex_is_mul, e.is_mul);
          chk($sformatf("sb_rs_data@%0h", e.pc), ex_rs_data, e.rs_data);
          chk($sformatf("sb_rt_data@%0h", e.pc), ex_rt_data, e.rt_data);
          chk($sformatf("sb_imm@%0h", e.pc), ex_imm, e.imm);
        end
      end
      prev_valid = ex_valid;
      last_pc    = ex_pc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with mem_stall asserted: stall_id must still read 0.
    mem_stall = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    mem_stall = 1'b0;
    rst_n = 1'b1;

    // Load-use on rs: one stall cycle, one bubble, then ADD latches with dest=rd.
    send(OP_LDW, 32'h100, 5'd1, 5'd3, 5'd0,  C_LDW,   5'd3, 1'b0, 0, 1'b0);
    send(OP_R,   32'h104, 5'd3, 5'd4, 5'd5,  C_RTYPE, 5'd5, 1'b0, 1, 1'b0);
    // Same rt dependency but ignore_op2: no stall.
    send(OP_LDW, 32'h108, 5'd1, 5'd3, 5'd0,  C_LDW,   5'd3, 1'b0, 0, 1'b0);
    send(OP_R,   32'h10C, 5'd1, 5'd3, 5'd6,  C_IGN,   5'd6, 1'b0, 0, 1'b0);
    // rt dependency on an R-type that really reads rt: stall.
    send(OP_LDW, 32'h110, 5'd1, 5'd3, 5'd0,  C_LDW,   5'd3, 1'b0, 0, 1'b0);
    send(OP_R,   32'h114, 5'd1, 5'd3, 5'd9,  C_RTYPE, 5'd9, 1'b0, 1, 1'b0);
    // Load into r0 followed by an r0 reader: no stall.
    send(OP_LDW, 32'h118, 5'd1, 5'd0, 5'd0,  C_LDW,   5'd0, 1'b0, 0, 1'b0);
    send(OP_R,   32'h11C, 5'd0, 5'd0, 5'd10, C_RTYPE, 5'd10, 1'b0, 0, 1'b0);
    // Store: no destination, rt preserved.
    send(OP_STW, 32'h120, 5'd2, 5'd7, 5'd0,  C_STW,   5'd0, 1'b0, 0, 1'b0);
    // tlb_write/iret pass through; reg_dst without reg_write gives dest 0.
    send(6'h10,  32'h124, 5'd1, 5'd2, 5'd11, C_TLBI,  5'd11, 1'b0, 0, 1'b0);
    send(OP_R,   32'h128, 5'd1, 5'd2, 5'd12, C_NOWR,  5'd0, 1'b0, 0, 1'b0);

    // MUL hold: follower is held 3 cycles and latches on the 4th edge.
    send(OP_MUL, 32'h180, 5'd1, 5'd2, 5'd8,  C_RTYPE, 5'd8, 1'b1, 0, 1'b0);
    send(OP_R,   32'h184, 5'd8, 5'd8, 5'd13, C_RTYPE, 5'd13, 1'b0, 3, 1'b1);

    // Load feeding a MUL: bubble first, then the MUL latches and holds.
    send(OP_LDW, 32'h190, 5'd1, 5'd4, 5'd0,  C_LDW,   5'd4, 1'b0, 0, 1'b0);
    send(OP_MUL, 32'h194, 5'd4, 5'd5, 5'd14, C_RTYPE, 5'd14, 1'b1, 1, 1'b0);
    send(OP_R,   32'h198, 5'd1, 5'd2, 5'd15, C_RTYPE, 5'd15, 1'b0, 3, 1'b1);

    // mem_stall for 2 cycles at mul_cnt=2: 6 cycles of occupancy in total.
    send(OP_MUL, 32'h200, 5'd1, 5'd2, 5'd16, C_RTYPE, 5'd16, 1'b1, 0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        drive(OP_R, 32'h204, 5'd1, 5'd2, 5'd17, C_RTYPE);
        push(32'h204, 5'd1, 5'd2, C_RTYPE, 5'd17, 1'b0);
      end
      mem_stall = (c == 1 || c == 2);
      #1;
      chk($sformatf("memstall_mul_busy_c%0d", c), mul_busy, (c <= 4) ? 1 : 0);
      chk($sformatf("memstall_stall_id_c%0d", c), stall_id, (c <= 4) ? 1 : 0);
      chk($sformatf("memstall_ex_pc_c%0d", c), ex_pc, 32'h200);
    end
    @(negedge clk);
    chk("memstall_follower_pc", ex_pc, 32'h204);
    chk("memstall_follower_valid", ex_valid, 1);

    // Flush while mul_cnt=2 and mem_stall=1.
    send(OP_MUL, 32'h300, 5'd1, 5'd2, 5'd18, C_RTYPE, 5'd18, 1'b1, 0, 1'b0);
    @(negedge clk);
    id_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    mem_stall = 1'b1;
    #1;
    chk("flush_pre_mul_busy", mul_busy, 1);
    @(negedge clk);
    chk("flush_ex_valid", ex_valid, 0);
    chk("flush_ex_ctrl", ex_ctrl, 0);
    chk("flush_ex_dest", ex_dest, 0);
    chk("flush_ex_is_mul", ex_is_mul, 0);
    chk("flush_mul_busy", mul_busy, 0);
    chk("flush_data_hold", ex_pc, 32'h300);
    chk("flush_stall_memstall", stall_id, 1);
    flush = 1'b0;
    mem_stall = 1'b0;
    #1;
    chk("flush_stall_released", stall_id, 0);

    // Asynchronous reset in the middle of a MUL hold.
    send(OP_MUL, 32'h400, 5'd1, 5'd2, 5'd19, C_RTYPE, 5'd19, 1'b1, 0, 1'b0);
    @(negedge clk);
    drive(OP_R, 32'h404, 5'd1, 5'd2, 5'd20, C_RTYPE);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    mem_stall = 1'b1;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    id_valid = 1'b0;
    mem_stall = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_reset_stall_id", stall_id, 0);
    chk("post_reset_mul_busy", mul_busy, 0);
    send(OP_R, 32'h408, 5'd1, 5'd2, 5'd21, C_RTYPE, 5'd21, 1'b0, 0, 1'b0);

    @(negedge clk);
    id_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
